// File: rtl/lbp_pkg.sv
// LBP shared definitions: geometry, FSM states,
// window type and neighbour bit order.
package lbp_pkg;

  localparam int IMG_W  = 128;
  localparam int ADDR_W = 14;

  function automatic int hi_bound(input int w);
    return w - 2;
  endfunction

  localparam int INT_LO = 1;
  localparam int INT_HI = hi_bound(IMG_W);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_WRITE,
    S_DONE
  } state_t;

  // window indexed [row][col], centre at [1][1]
  typedef logic [2:0][2:0][7:0] win_t;

  localparam logic [1:0] NB_R [8] = '{
    2'd0, 2'd0, 2'd0, 2'd1,
    2'd1, 2'd2, 2'd2, 2'd2
  };
  localparam logic [1:0] NB_C [8] = '{
    2'd0, 2'd1, 2'd2, 2'd0,
    2'd2, 2'd0, 2'd1, 2'd2
  };

endpackage

// File: rtl/lbp_encode.sv
// LBP encoder: bit p set when neighbour p
// is >= the centre pixel.
module lbp_encode
  import lbp_pkg::*;
(
  input  win_t       win,
  output logic [7:0] code
);

  for (genvar p = 0; p < 8; p++) begin : g_bit
    assign code[p] =
      win[NB_R[p]][NB_C[p]] >= win[1][1];
  end

endmodule

// File: rtl/lbp.sv
// LBP engine: sliding 3x3 window over the gray
// image, one registered result per interior pixel.
module lbp
  import lbp_pkg::*;
#(
  parameter int IMG_W  = lbp_pkg::IMG_W,
  parameter int ADDR_W = lbp_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              gray_ready,
  output logic              gray_req,
  output logic [ADDR_W-1:0] gray_addr,
  input  logic [7:0]        gray_data,
  output logic              lbp_valid,
  output logic [ADDR_W-1:0] lbp_addr,
  output logic [7:0]        lbp_data,
  output logic              finish
);

  localparam int CW = $clog2(IMG_W);
  localparam logic [CW-1:0] LB = CW'(INT_LO);
  localparam logic [CW-1:0] HB =
    CW'(hi_bound(IMG_W));

  state_t        state, nstate;
  logic [CW-1:0] r, c;
  logic [CW-1:0] ra, ca;
  logic [1:0]    ky, kx;
  logic          last_read;
  win_t          win, win_nxt;
  logic [7:0]    code;

  always_comb begin
    last_read =
      (state == S_LOAD && ky == 2'd2
        && kx == 2'd2)
      || (state == S_SHIFT && ky == 2'd2);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (state)
      S_IDLE:
        if (gray_ready) nstate = S_LOAD;
      S_LOAD, S_SHIFT:
        if (last_read) nstate = S_WRITE;
      S_WRITE:
        if (c < HB)      nstate = S_SHIFT;
        else if (r < HB) nstate = S_LOAD;
        else             nstate = S_DONE;
      S_DONE:
        nstate = S_DONE;
      default:
        nstate = S_IDLE;
    endcase
  end

  // row start reads column 0..2; shifts read c+1
  always_comb begin
    gray_req = (state == S_LOAD)
            || (state == S_SHIFT);
    ra = r - CW'(1) + CW'(ky);
    ca = (state == S_LOAD) ? CW'(kx)
                           : c + CW'(1);
    gray_addr = gray_req
              ? ADDR_W'({ra, ca}) : '0;
  end

  always_comb begin
    win_nxt = win;
    if (state == S_LOAD)
      win_nxt[ky][kx] = gray_data;
    if (state == S_SHIFT)
      win_nxt[ky][2] = gray_data;
    if (state == S_WRITE && nstate == S_SHIFT)
      for (int i = 0; i < 3; i++) begin
        win_nxt[i][0] = win[i][1];
        win_nxt[i][1] = win[i][2];
      end
  end

  // encode the window including the pixel
  // arriving on the final read
  lbp_encode u_enc (
    .win  (win_nxt),
    .code (code)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r         <= '0;
      c         <= '0;
      ky        <= '0;
      kx        <= '0;
      win       <= '0;
      lbp_valid <= 1'b0;
      lbp_addr  <= '0;
      lbp_data  <= '0;
      finish    <= 1'b0;
    end else begin
      win       <= win_nxt;
      lbp_valid <= last_read;
      finish    <= finish
                 | (nstate == S_DONE);
      if (last_read) begin
        lbp_addr <= ADDR_W'({r, c});
        lbp_data <= code;
        ky       <= '0;
        kx       <= '0;
      end else if (state == S_LOAD) begin
        if (kx == 2'd2) begin
          kx <= '0;
          ky <= ky + 2'd1;
        end else begin
          kx <= kx + 2'd1;
        end
      end else if (state == S_SHIFT) begin
        ky <= ky + 2'd1;
      end
      if (state == S_IDLE) begin
        r <= LB;
        c <= LB;
      end
      if (state == S_WRITE) begin
        if (nstate == S_SHIFT) begin
          c <= c + CW'(1);
        end else if (nstate == S_LOAD) begin
          r <= r + CW'(1);
          c <= LB;
        end
      end
    end
  end

endmodule

// File: tb/tb_lbp.sv
// Directed bench for lbp on a 32x32 image so
// several full-image runs fit the cycle budget.
module tb_lbp;

  localparam int W  = 32;
  localparam int AW = 10;
  localparam int N  = W * W;
  localparam int NI = (W - 2) * (W - 2);
  localparam int SP = (W / 2) * W + W / 2;

  logic          clk;
  logic          reset;
  logic          gray_ready;
  logic          gray_req;
  logic [AW-1:0] gray_addr;
  logic [7:0]    gray_data;
  logic          lbp_valid;
  logic [AW-1:0] lbp_addr;
  logic [7:0]    lbp_data;
  logic          finish;

  lbp #(.IMG_W(W), .ADDR_W(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .gray_ready (gray_ready),
    .gray_req   (gray_req),
    .gray_addr  (gray_addr),
    .gray_data  (gray_data),
    .lbp_valid  (lbp_valid),
    .lbp_addr   (lbp_addr),
    .lbp_data   (lbp_data),
    .finish     (finish)
  );

  logic [7:0] img [N];
  logic [7:0] res [N];
  bit         seen [N];

  assign gray_data = img[gray_addr];

  int checks = 0;
  int errors = 0;
  int wcnt, dups, frise, vf, early;
  int cyc, last_wr, fin_cyc;
  bit started, fin_q;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (reset) begin
      if (lbp_valid) begin
        if (seen[lbp_addr]) dups++;
        seen[lbp_addr] = 1'b1;
        res[lbp_addr]  = lbp_data;
        wcnt++;
        last_wr = cyc;
      end
      if (finish && !fin_q) begin
        frise++;
        fin_cyc = cyc;
      end
      if (finish && (gray_req || lbp_valid)) vf++;
      if (!started && (gray_req || lbp_valid))
        early++;
    end
    fin_q = finish;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  function automatic bit interior(input int a);
    int r = a / W;
    int c = a % W;
    return r >= 1 && r <= W - 2
        && c >= 1 && c <= W - 2;
  endfunction

  function automatic logic [7:0] lbp_ref(
    input int a);
    int dr [8] = '{-1, -1, -1, 0, 0, 1, 1, 1};
    int dc [8] = '{-1, 0, 1, -1, 1, -1, 0, 1};
    int r = a / W;
    int c = a % W;
    logic [7:0] v = '0;
    for (int p = 0; p < 8; p++)
      v[p] = img[(r + dr[p]) * W + c + dc[p]]
          >= img[a];
    return v;
  endfunction

  function automatic int cnt_bad(
    input logic [7:0] e);
    int n = 0;
    for (int a = 0; a < N; a++)
      if (res[a] !== (interior(a) ? e : 8'h00))
        n++;
    return n;
  endfunction

  function automatic int cnt_model();
    int n = 0;
    for (int a = 0; a < N; a++)
      if (res[a] !== (interior(a)
                      ? lbp_ref(a) : 8'h00))
        n++;
    return n;
  endfunction

  task automatic clear_stats();
    for (int a = 0; a < N; a++) begin
      res[a]  = 8'h00;
      seen[a] = 1'b0;
    end
    wcnt = 0; dups = 0; frise = 0;
    vf = 0; early = 0; started = 1'b0;
    last_wr = 0; fin_cyc = 0;
  endtask

  task automatic chk_zero(input string t);
    chk({t, "_req"},   gray_req,  0);
    chk({t, "_gaddr"}, gray_addr, 0);
    chk({t, "_valid"}, lbp_valid, 0);
    chk({t, "_laddr"}, lbp_addr,  0);
    chk({t, "_ldata"}, lbp_data,  0);
    chk({t, "_fin"},   finish,    0);
  endtask

  task automatic do_reset(input string t);
    gray_ready = 1'b0;
    reset      = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk_zero({t, "_rst"});
    @(negedge clk) reset = 1'b1;
    clear_stats();
  endtask

  task automatic wait_done(input string t);
    int n = 0;
    while (!finish && n < 80000) begin
      @(negedge clk);
      n++;
    end
    chk({t, "_done"}, finish, 1);
    repeat (4) @(negedge clk);
    chk({t, "_writes"}, wcnt,  NI);
    chk({t, "_dups"},   dups,  0);
    chk({t, "_frise"},  frise, 1);
    chk({t, "_busy"},   vf,    0);
    chk({t, "_gap"}, fin_cyc - last_wr, 1);
    chk({t, "_model"}, cnt_model(), 0);
  endtask

  task automatic start();
    gray_ready = 1'b1;
    started    = 1'b1;
  endtask

  initial begin
    int n;
    reset      = 1'b0;
    gray_ready = 1'b0;

    for (int a = 0; a < N; a++) img[a] = 8'h55;
    do_reset("const");
    start();
    wait_done("const");
    chk("const_all", cnt_bad(8'hFF), 0);

    for (int a = 0; a < N; a++)
      img[a] = 8'(a % W);
    do_reset("colr");
    start();
    wait_done("colr");
    chk("colr_all", cnt_bad(8'hD6), 0);

    for (int a = 0; a < N; a++)
      img[a] = 8'(a / W);
    do_reset("rowr");
    start();
    wait_done("rowr");
    chk("rowr_all", cnt_bad(8'hF8), 0);

    for (int a = 0; a < N; a++) img[a] = 8'h10;
    img[SP] = 8'hFF;
    do_reset("spike");
    repeat (100) @(negedge clk);
    chk("hold_early", early, 0);
    start();
    repeat (20) @(negedge clk);
    gray_ready = 1'b0;
    wait_done("spike");
    chk("spike_ctr", res[SP], 8'h00);
    chk("spike_nb", res[SP - W - 1]
      & res[SP - W] & res[SP - W + 1]
      & res[SP - 1] & res[SP + 1]
      & res[SP + W - 1] & res[SP + W]
      & res[SP + W + 1], 8'hFF);
    chk("spike_rest", cnt_bad(8'hFF), 1);

    for (int a = 0; a < N; a++)
      img[a] = 8'($urandom_range(0, 255));
    img[3 * W + 4] = img[3 * W + 5];
    do_reset("rand");
    start();
    n = 0;
    while (!(lbp_valid
             && lbp_addr == AW'(16 * W + 10))
           && n < 80000) begin
      @(negedge clk);
      n++;
    end
    chk("mid_reached", lbp_valid, 1);
    #2 reset = 1'b0;
    #1 chk_zero("mid");
    repeat (2) @(negedge clk);
    chk_zero("mid_hold");
    reset = 1'b1;
    clear_stats();
    started = 1'b1;
    wait_done("rerun");

    $display("CHECKS %0d ERRORS %0d",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/lbp.md
LBP -- requirements
Module: lbp

Interface
REQ-001 Parameters: IMG_W, default 128, image width/height in pixels (square image); ADDR_W, default 14, pixel address width (log2 of IMG_W squared).
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 gray_ready  input  1  gray-image source available; high means requests may start.
REQ-005 gray_req  output  1  read strobe for gray_addr.
REQ-006 gray_addr  output  14  gray pixel address = row*128 + col, i.e. {row[6:0], col[6:0]}.
REQ-007 gray_data  input  8  pixel value; valid in the same cycle as gray_req; captured at the next rising edge.
REQ-008 lbp_valid  output  1  write strobe for lbp_addr/lbp_data.
REQ-009 lbp_addr  output  14  result address, same mapping as gray_addr.
REQ-010 lbp_data  output  8  LBP code.
REQ-011 finish  output  1  whole image processed; sticky.

Function
REQ-012 Center gc at (r,c); neighbours: g0=(r-1,c-1), g1=(r-1,c), g2=(r-1,c+1), g3=(r,c-1), g4=(r,c+1), g5=(r+1,c-1), g6=(r+1,c), g7=(r+1,c+1).
REQ-013 lbp_data bit p = 1 when gp >= gc (unsigned 8-bit compare; equality gives 1), else 0.
REQ-014 Only interior pixels (1..126 in both row and column) are computed and written; exactly 126*126 = 15876 writes, each address written once.
REQ-015 Border pixels are never written; the result memory is pre-cleared to 0, so border results read as 0x00.
REQ-016 No gray_req before gray_ready is seen high; once started, gray_ready is not re-checked.
REQ-017 Each request cycle drives gray_req=1 and a valid gray_addr; the pixel is registered at that cycle's rising edge. Zero-wait read with no back-pressure.
REQ-018 Sliding 3x3 window in raster order, row by row:
- Row start: 9 reads load the window for column 1.
- Each further column: shift the window left by one column and read the 3 new right-column pixels.
REQ-019 The LBP result is registered; lbp_valid is high for exactly one cycle per result, with lbp_addr/lbp_data stable for that whole cycle.
REQ-020 FSM states IDLE, LOAD (row start), SHIFT (3 reads), WRITE, DONE.
- IDLE->LOAD on gray_ready.
- LOAD->WRITE after 9 reads.
- WRITE->SHIFT if c<126, else ->LOAD for the next row if r<126, else ->DONE.
- SHIFT->WRITE after 3 reads.
REQ-021 Throughput: the full image completes within 80,000 cycles of gray_ready rising.
REQ-022 finish rises in the cycle after the final write (address 126*128+126 = 16254), never together with lbp_valid.
REQ-023 finish stays high until reset; in DONE, gray_req and lbp_valid stay 0.
REQ-024 Row/column counters use 7 bits; addresses are formed by concatenation, with no wrap beyond 0..127.

Reset
REQ-025 While reset is low: gray_req=0, gray_addr=0, lbp_valid=0, lbp_addr=0, lbp_data=0, finish=0, FSM=IDLE, counters and window cleared.
REQ-026 Reset asserted mid-image aborts at once; after release, processing restarts from (1,1) when gray_ready is high.

Structure
REQ-027 Shared package lbp_pkg holds IMG_W, ADDR_W, the interior bounds (1, 126), the FSM state enum, and the neighbour bit-order constants.
REQ-028 One combinational sub-module, lbp_encode: 3x3 window (9 x 8 bits) in, 8-bit code out per REQ-012/013.
REQ-029 The top-level module holds the FSM, counters, address generation and window registers.

Verification
REQ-030 Constant image, all 0x55 -> every interior address 0xFF; every border address 0x00; finish rises once.
REQ-031 Column ramp, gray=col -> every interior result 0xD6; write count 15876.
REQ-032 Row ramp, gray=row -> every interior result 0xF8.
REQ-033 Single spike, (64,64)=0xFF, all other pixels 0x10:
- address 8256 gives 0x00;
- its 8 neighbours give 0xFF;
- all other interior pixels give 0xFF.
REQ-034 Hold gray_ready low for 100 cycles after reset -> no gray_req, no lbp_valid; normal completion once gray_ready rises.
REQ-035 Random image, reset pulsed low mid-row 60 -> all outputs 0 during reset; rerun matches the software LBP model with 0 mismatches; finish asserted within 80,000 cycles.
